// File: rtl/key_gen_ctrl.sv
// RSA key-generation sequencer: fetches two distinct primes, computes n and phi on the
// shared multiplier, asks the inverse unit for d, and presents (n, e, d) to the key manager.
module key_gen_ctrl #(
  parameter int E_KEY   = 65537,
  parameter int MAX_TRY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        prime_req,
  input  logic        prime_ack,
  input  logic [15:0] prime_val,
  output logic        mul_start,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_p,
  output logic        inv_start,
  output logic [31:0] inv_a,
  output logic [31:0] inv_m,
  input  logic        inv_done,
  input  logic        inv_ok,
  input  logic [31:0] inv_res,
  output logic [31:0] n_key_gen,
  output logic [31:0] e_key_gen,
  output logic [31:0] d_key_gen,
  output logic        n_key_valid,
  output logic        e_key_valid,
  output logic        d_key_valid,
  output logic        fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_P, S_GET_Q, S_MUL_N, S_MUL_PHI, S_INV, S_EMIT, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  try_cnt_q, try_cnt_d, try_inc;
  logic [15:0] p_q, p_d, q_q, q_d;
  logic [31:0] n_q, n_d;
  logic        busy_q, busy_d;
  logic        prime_req_q, prime_req_d;
  logic        mul_start_q, mul_start_d;
  logic [15:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        inv_start_q, inv_start_d;
  logic [31:0] inv_m_q, inv_m_d;
  logic [31:0] n_key_q, n_key_d, e_key_q, e_key_d, d_key_q, d_key_d;
  logic        key_valid_q, key_valid_d;
  logic        fail_q, fail_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    try_cnt_d   = try_cnt_q;
    try_inc     = try_cnt_q + 4'd1;
    p_d         = p_q;
    q_d         = q_q;
    n_d         = n_q;
    prime_req_d = prime_req_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    inv_start_d = 1'b0;
    inv_m_d     = inv_m_q;
    n_key_d     = n_key_q;
    e_key_d     = e_key_q;
    d_key_d     = d_key_q;
    key_valid_d = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_GET_P;
          try_cnt_d   = 4'd0;
          prime_req_d = 1'b1;
        end else begin
          prime_req_d = 1'b0;
        end
      end
      // Acks only count while the request is visible; the drop after each ack
      // gives the prime source a one-cycle gap between requests.
      S_GET_P: begin
        if (prime_req_q && prime_ack) begin
          p_d         = prime_val;
          prime_req_d = 1'b0;
          state_d     = S_GET_Q;
        end else begin
          prime_req_d = 1'b1;
        end
      end
      S_GET_Q: begin
        if (prime_req_q && prime_ack) begin
          prime_req_d = 1'b0;
          if (prime_val != p_q) begin
            q_d         = prime_val;
            state_d     = S_MUL_N;
            mul_start_d = 1'b1;
            mul_a_d     = p_q;
            mul_b_d     = prime_val;
          end else begin
            q_d = q_q;
          end
        end else begin
          prime_req_d = 1'b1;
        end
      end
      // A done coincident with our own start pulse belongs to nobody.
      S_MUL_N: begin
        if (mul_done && !mul_start_q) begin
          n_d         = mul_p;
          state_d     = S_MUL_PHI;
          mul_start_d = 1'b1;
          mul_a_d     = p_q - 16'd1;
          mul_b_d     = q_q - 16'd1;
        end else begin
          n_d = n_q;
        end
      end
      S_MUL_PHI: begin
        if (mul_done && !mul_start_q) begin
          inv_m_d     = mul_p;
          inv_start_d = 1'b1;
          state_d     = S_INV;
        end else begin
          inv_m_d = inv_m_q;
        end
      end
      S_INV: begin
        if (inv_done && !inv_start_q) begin
          if (inv_ok) begin
            // Loaded on the edge into EMIT so keys and ticks appear together.
            n_key_d     = n_q;
            e_key_d     = 32'(E_KEY);
            d_key_d     = inv_res;
            key_valid_d = 1'b1;
            state_d     = S_EMIT;
          end else begin
            try_cnt_d = try_inc;
            if (try_inc == 4'(MAX_TRY)) begin
              fail_d  = 1'b1;
              state_d = S_FAIL;
            end else begin
              prime_req_d = 1'b1;
              state_d     = S_GET_P;
            end
          end
        end else begin
          try_cnt_d = try_cnt_q;
        end
      end
      S_EMIT:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      try_cnt_q   <= 4'd0;
      p_q         <= 16'd0;
      q_q         <= 16'd0;
      n_q         <= 32'd0;
      busy_q      <= 1'b0;
      prime_req_q <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= 16'd0;
      mul_b_q     <= 16'd0;
      inv_start_q <= 1'b0;
      inv_m_q     <= 32'd0;
      n_key_q     <= 32'd0;
      e_key_q     <= 32'd0;
      d_key_q     <= 32'd0;
      key_valid_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      try_cnt_q   <= try_cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      prime_req_q <= prime_req_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      inv_start_q <= inv_start_d;
      inv_m_q     <= inv_m_d;
      n_key_q     <= n_key_d;
      e_key_q     <= e_key_d;
      d_key_q     <= d_key_d;
      key_valid_q <= key_valid_d;
      fail_q      <= fail_d;
    end
  end

  assign busy        = busy_q;
  assign prime_req   = prime_req_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign inv_start   = inv_start_q;
  assign inv_a       = 32'(E_KEY);
  assign inv_m       = inv_m_q;
  assign n_key_gen   = n_key_q;
  assign e_key_gen   = e_key_q;
  assign d_key_gen   = d_key_q;
  assign n_key_valid = key_valid_q;
  assign e_key_valid = key_valid_q;
  assign d_key_valid = key_valid_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_key_gen_ctrl.sv
// Directed bench for key_gen_ctrl: bench-side prime source, multiplier and inverse stubs
// driven from one sequence, with immediate-assertion checks at each observation point.
module tb_key_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, prime_req, mul_start, inv_start;
  logic        prime_ack = 1'b0;
  logic [15:0] prime_val = 16'd0;
  logic [15:0] mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [31:0] mul_p = 32'd0;
  logic [31:0] inv_a, inv_m;
  logic        inv_done = 1'b0;
  logic        inv_ok = 1'b0;
  logic [31:0] inv_res = 32'd0;
  logic [31:0] n_key_gen, e_key_gen, d_key_gen;
  logic        n_key_valid, e_key_valid, d_key_valid, fail;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_fail = 0, n_mul_start = 0, n_req_rise = 0;
  logic req_prev = 1'b0;
  int v0, f0, m0, r0;

  always #5 clk = ~clk;

  key_gen_ctrl #(.E_KEY(65537), .MAX_TRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .prime_req(prime_req), .prime_ack(prime_ack), .prime_val(prime_val),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p),
    .inv_start(inv_start), .inv_a(inv_a), .inv_m(inv_m), .inv_done(inv_done),
    .inv_ok(inv_ok), .inv_res(inv_res),
    .n_key_gen(n_key_gen), .e_key_gen(e_key_gen), .d_key_gen(d_key_gen),
    .n_key_valid(n_key_valid), .e_key_valid(e_key_valid), .d_key_valid(d_key_valid),
    .fail(fail)
  );

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (n_key_valid) n_valid++;
    if (fail) n_fail++;
    if (mul_start) n_mul_start++;
    if (prime_req && !req_prev) n_req_rise++;
    req_prev = prime_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic serve_prime(input logic [15:0] val, input int dly);
    int t = 0;
    while (prime_req !== 1'b1 && t < 200) begin tick(); t++; end
    chk("prime_req_seen", 32'(prime_req), 32'd1);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("prime_req_hold", 32'(prime_req), 32'd1);
    end
    prime_val = val; prime_ack = 1'b1;
    tick();
    prime_ack = 1'b0; prime_val = 16'd0;
    chk("prime_req_drop", 32'(prime_req), 32'd0);
  endtask

  task automatic serve_mul(input logic [15:0] a, input logic [15:0] b, input int dly,
                           input logic early_done, input logic start_poke);
    int t = 0;
    logic [31:0] prod;
    prod = {16'd0, a} * {16'd0, b};
    while (mul_start !== 1'b1 && t < 200) begin tick(); t++; end
    chk("mul_start_seen", 32'(mul_start), 32'd1);
    chk("mul_a", 32'(mul_a), 32'(a));
    chk("mul_b", 32'(mul_b), 32'(b));
    mul_done = early_done; mul_p = 32'hDEAD_BEEF; start = start_poke;
    tick();
    mul_done = 1'b0; start = 1'b0;
    chk("mul_start_pulse", 32'(mul_start), 32'd0);
    for (int i = 0; i < dly; i++) begin
      chk("mul_a_hold", 32'(mul_a), 32'(a));
      chk("mul_b_hold", 32'(mul_b), 32'(b));
      tick();
    end
    chk("mul_a_hold", 32'(mul_a), 32'(a));
    mul_p = prod; mul_done = 1'b1;
    tick();
    mul_done = 1'b0; mul_p = 32'd0;
  endtask

  task automatic serve_inv(input logic [31:0] m, input logic ok, input logic [31:0] res, input int dly);
    int t = 0;
    while (inv_start !== 1'b1 && t < 200) begin tick(); t++; end
    chk("inv_start_seen", 32'(inv_start), 32'd1);
    chk("inv_m", inv_m, m);
    chk("inv_a", inv_a, 32'd65537);
    tick();
    for (int i = 0; i < dly; i++) begin
      chk("inv_m_hold", inv_m, m);
      tick();
    end
    inv_done = 1'b1; inv_ok = ok; inv_res = res;
    tick();
    inv_done = 1'b0; inv_ok = 1'b0; inv_res = 32'd0;
  endtask

  task automatic expect_emit(input logic [31:0] n, input logic [31:0] d, input logic poke);
    int t = 0;
    while (n_key_valid !== 1'b1 && t < 50) begin tick(); t++; end
    chk("n_key_valid", 32'(n_key_valid), 32'd1);
    chk("e_key_valid", 32'(e_key_valid), 32'd1);
    chk("d_key_valid", 32'(d_key_valid), 32'd1);
    chk("n_key_gen", n_key_gen, n);
    chk("e_key_gen", e_key_gen, 32'd65537);
    chk("d_key_gen", d_key_gen, d);
    chk("busy_in_emit", 32'(busy), 32'd1);
    start = poke;
    tick();
    start = 1'b0;
    chk("valid_one_cycle", 32'({n_key_valid, e_key_valid, d_key_valid}), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("n_key_hold", n_key_gen, n);
    tick();
    chk("busy_stays_low", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prime_req", 32'(prime_req), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_inv_start", 32'(inv_start), 32'd0);
    chk("rst_inv_a", inv_a, 32'd65537);
    chk("rst_n_key", n_key_gen, 32'd0);
    chk("rst_e_key", e_key_gen, 32'd0);
    chk("rst_d_key", d_key_gen, 32'd0);
    chk("rst_valid", 32'(n_key_valid), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic run with start pokes during MUL_N and EMIT
    v0 = n_valid; m0 = n_mul_start;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    serve_prime(16'd65521, 0);
    serve_prime(16'd65519, 0);
    serve_mul(16'd65521, 16'd65519, 2, 1'b0, 1'b1);
    serve_mul(16'd65520, 16'd65518, 0, 1'b0, 1'b0);
    serve_inv(32'd4292739360, 1'b1, 32'h1234_5678, 0);
    expect_emit(32'd4292870399, 32'h1234_5678, 1'b1);
    chk("basic_one_triple", 32'(n_valid - v0), 32'd1);
    chk("basic_two_muls", 32'(n_mul_start - m0), 32'd2);

    // Duplicate prime, plus a mul_done coincident with mul_start
    m0 = n_mul_start; v0 = n_valid;
    start = 1'b1; tick(); start = 1'b0;
    serve_prime(16'd65521, 0);
    serve_prime(16'd65521, 0);
    serve_prime(16'd65519, 0);
    serve_mul(16'd65521, 16'd65519, 1, 1'b1, 1'b0);
    serve_mul(16'd65520, 16'd65518, 1, 1'b1, 1'b0);
    serve_inv(32'd4292739360, 1'b1, 32'hCAFE_BABE, 1);
    chk("dup_try_cnt", 32'(dut.try_cnt_q), 32'd0);
    expect_emit(32'd4292870399, 32'hCAFE_BABE, 1'b0);
    chk("dup_two_muls", 32'(n_mul_start - m0), 32'd2);
    chk("dup_one_triple", 32'(n_valid - v0), 32'd1);

    // Inverse retry then fail (MAX_TRY = 2)
    v0 = n_valid; f0 = n_fail; r0 = n_req_rise;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      serve_prime(16'd65521, 0);
      serve_prime(16'd65519, 0);
      serve_mul(16'd65521, 16'd65519, 0, 1'b0, 1'b0);
      serve_mul(16'd65520, 16'd65518, 0, 1'b0, 1'b0);
      serve_inv(32'd4292739360, 1'b0, 32'd0, 0);
    end
    chk("fail_pulse", 32'(fail), 32'd1);
    chk("fail_keeps_n", n_key_gen, 32'd4292870399);
    chk("fail_keeps_d", d_key_gen, 32'hCAFE_BABE);
    tick();
    chk("fail_one_cycle", 32'(fail), 32'd0);
    chk("fail_busy_low", 32'(busy), 32'd0);
    tick();
    chk("fail_count", 32'(n_fail - f0), 32'd1);
    chk("fail_no_valid", 32'(n_valid - v0), 32'd0);
    chk("fail_reentered_get_p", 32'(n_req_rise - r0), 32'd4);

    // Slow units
    v0 = n_valid;
    start = 1'b1; tick(); start = 1'b0;
    serve_prime(16'd65521, 20);
    serve_prime(16'd65519, 20);
    serve_mul(16'd65521, 16'd65519, 5, 1'b0, 1'b0);
    serve_mul(16'd65520, 16'd65518, 5, 1'b0, 1'b0);
    serve_inv(32'd4292739360, 1'b1, 32'h1234_5678, 5);
    expect_emit(32'd4292870399, 32'h1234_5678, 1'b0);
    chk("slow_one_triple", 32'(n_valid - v0), 32'd1);

    // Reset during INV, then a stray inv_done
    v0 = n_valid;
    start = 1'b1; tick(); start = 1'b0;
    serve_prime(16'd65521, 0);
    serve_prime(16'd65519, 0);
    serve_mul(16'd65521, 16'd65519, 0, 1'b0, 1'b0);
    serve_mul(16'd65520, 16'd65518, 0, 1'b0, 1'b0);
    for (int t = 0; t < 200 && inv_start !== 1'b1; t++) tick();
    chk("rst_run_inv_start", 32'(inv_start), 32'd1);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_prime_req", 32'(prime_req), 32'd0);
    chk("mid_rst_mul_start", 32'(mul_start), 32'd0);
    chk("mid_rst_inv_start", 32'(inv_start), 32'd0);
    chk("mid_rst_n_key", n_key_gen, 32'd0);
    chk("mid_rst_e_key", e_key_gen, 32'd0);
    chk("mid_rst_d_key", d_key_gen, 32'd0);
    chk("mid_rst_inv_a", inv_a, 32'd65537);
    inv_done = 1'b1; inv_ok = 1'b1; inv_res = 32'h0BAD_0BAD;
    tick();
    inv_done = 1'b0; inv_ok = 1'b0; inv_res = 32'd0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_valid", 32'(n_key_valid), 32'd0);
      chk("stray_busy_low", 32'(busy), 32'd0);
      tick();
    end
    chk("stray_valid_count", 32'(n_valid - v0), 32'd0);
    chk("stray_d_key", d_key_gen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
